// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache.
// Optional hit/miss counters enabled by DCACHE_STATS_EN.
module dcache_wt #(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_re,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_rw,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_mask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int WA_W  = IDX_W + OFF_W;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE,
    RESP
  } state_t;

  state_t state, state_d;

  logic [TAG_W-1:0] tag_mem [LINES];
  logic [31:0]      data_mem [LINES*LINE_WORDS];
  logic [LINES-1:0] valid_q;

  logic [29:0]      req_wa;
  logic [31:0]      req_din;
  logic [3:0]       req_mask;
  logic             req_wr;
  logic             cmp_q;
  logic             hit_q;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_valid;
  logic [31:0]      rd_word;
  logic [31:0]      resp_word;
  logic [31:0]      dout_q;
  logic [OFF_W:0]   req_cnt;
  logic [OFF_W-1:0] resp_cnt;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] cpu_idx;
  logic [WA_W-1:0]  cpu_wa;
  logic             hit;
  logic             last_beat;
  logic             req_fire;
  logic             accept;
  logic             unused_ok;

  assign req_tag   = req_wa[29 -: TAG_W];
  assign req_idx   = req_wa[OFF_W +: IDX_W];
  assign req_off   = req_wa[OFF_W-1:0];
  assign cpu_idx   = cpu_addr[2+OFF_W +: IDX_W];
  assign cpu_wa    = cpu_addr[2 +: WA_W];
  assign unused_ok = ^cpu_addr[1:0];

  assign hit       = rd_valid && (rd_tag == req_tag);
  assign last_beat = mem_resp_valid
                  && (resp_cnt == OFF_W'(LINE_WORDS-1));
  assign req_fire  = mem_req_valid && mem_req_ready;
  assign accept    = (cpu_re || (|cpu_we))
                  && (state == RESP
                      || (state == IDLE && !stall));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d       = state;
    stall         = 1'b0;
    cpu_dout      = dout_q;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    mem_req_mask  = '0;
    unique case (state)
      IDLE: begin
        if (cmp_q) begin
          if (req_wr) begin
            stall   = 1'b1;
            state_d = WRITE;
          end else if (hit) begin
            cpu_dout = rd_word;
          end else begin
            stall   = 1'b1;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        stall         = 1'b1;
        mem_req_valid = !req_cnt[OFF_W];
        mem_req_addr  = {req_tag, req_idx,
                         req_cnt[OFF_W-1:0], 2'b00};
        if (last_beat) state_d = RESP;
      end
      WRITE: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {req_wa, 2'b00};
        mem_req_data  = req_din;
        mem_req_mask  = req_mask;
        if (mem_req_ready) state_d = RESP;
      end
      RESP: begin
        cpu_dout = resp_word;
        state_d  = IDLE;
      end
    endcase
  end

  // Arrays carry no reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_tag  <= tag_mem[cpu_idx];
      rd_word <= data_mem[cpu_wa];
    end
    if (!reset && state == REFILL && mem_resp_valid) begin
      data_mem[{req_idx, resp_cnt}] <= mem_resp_data;
      if (last_beat) tag_mem[req_idx] <= req_tag;
    end
    if (!reset && state == WRITE && mem_req_ready && hit_q) begin
      for (int b = 0; b < 4; b++) begin
        if (req_mask[b])
          data_mem[{req_idx, req_off}][8*b +: 8]
            <= req_din[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      cmp_q     <= 1'b0;
      hit_q     <= 1'b0;
      dout_q    <= '0;
      req_cnt   <= '0;
      resp_cnt  <= '0;
      resp_word <= '0;
      req_wa    <= '0;
      req_din   <= '0;
      req_mask  <= '0;
      req_wr    <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      dout_q <= cpu_dout;
      cmp_q  <= accept;
      if (accept) begin
        req_wa   <= cpu_addr[31:2];
        req_din  <= cpu_din;
        req_mask <= cpu_we;
        req_wr   <= |cpu_we;
        rd_valid <= valid_q[cpu_idx];
      end
      if (state == IDLE && cmp_q) begin
        hit_q     <= hit;
        req_cnt   <= '0;
        resp_cnt  <= '0;
        resp_word <= '0;
      end
      if (state == REFILL) begin
        if (req_fire)
          req_cnt <= req_cnt + (OFF_W+1)'(1);
        if (mem_resp_valid) begin
          resp_cnt <= resp_cnt + OFF_W'(1);
          if (resp_cnt == req_off)
            resp_word <= mem_resp_data;
          if (last_beat)
            valid_q[req_idx] <= 1'b1;
        end
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == IDLE && cmp_q && !req_wr) begin
      if (hit) hit_count  <= hit_count + 32'd1;
      else     miss_count <= miss_count + 32'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
